// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding the instruction memory.
// Selects jump/branch/sequential next-PC and halts in a sticky fault on bad targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    output logic [31:0] PC_out_address,
    output logic [31:0] PC_plus4,
    output logic        fetch_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // One bit wider than the PC so a 4 GiB memory limit cannot overflow.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH_WORDS) << 2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] candidate;
    logic        misaligned;
    logic        out_of_range;

    always_comb begin
        candidate = pc + 32'd4;
        if (jump_valid) begin
            candidate = jump_target;
        end else if (branch_taken) begin
            candidate = branch_target;
        end
        misaligned   = (candidate[1:0] != 2'b00);
        out_of_range = ({1'b0, candidate} >= PC_LIMIT);
    end

    assign PC_out_address = pc;
    assign PC_plus4       = pc + 32'd4;
    assign fetch_valid    = (state == ST_RUN);
    assign fault          = (state == ST_FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_VECTOR;
            fault_cause <= '0;
            fault_pc    <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (!stall) begin
                        // The instruction currently shown counts even when its successor faults.
                        if (fetch_count != '1) begin
                            fetch_count <= fetch_count + 32'd1;
                        end
                        if (misaligned || out_of_range) begin
                            state       <= ST_FAULT;
                            fault_cause <= {out_of_range, misaligned};
                            fault_pc    <= candidate;
                        end else begin
                            pc <= candidate;
                        end
                    end
                end
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; a second instance with a
// 4-word memory exercises the sequential run-off and combined fault causes.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump_valid;
    logic [31:0] branch_target, jump_target;

    logic [31:0] pc, plus4, fpc, cnt;
    logic        fv, flt;
    logic [1:0]  cause;

    logic [31:0] s_pc, s_plus4, s_fpc, s_cnt;
    logic        s_fv, s_flt;
    logic [1:0]  s_cause;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_VECTOR(32'h0), .IMEM_DEPTH_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .PC_out_address(pc), .PC_plus4(plus4), .fetch_valid(fv),
        .fault(flt), .fault_cause(cause), .fault_pc(fpc), .fetch_count(cnt)
    );

    pc_fetch_unit #(.RESET_VECTOR(32'h0), .IMEM_DEPTH_WORDS(4)) dut_small (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .PC_out_address(s_pc), .PC_plus4(s_plus4), .fetch_valid(s_fv),
        .fault(s_flt), .fault_cause(s_cause), .fault_pc(s_fpc), .fetch_count(s_cnt)
    );

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if ({pc, plus4, fv, flt, cause, fpc, cnt} !== {32'h0, 32'h4, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0}) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", {pc, plus4, fv, flt, cause, fpc, cnt}, {32'h0, 32'h4, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
        end
        rst = 1'b0;
        step();
        total++; if ({pc, fv, cnt} !== {32'h0, 1'b1, 32'd0}) begin
            bad++; $display("FAIL boot_exit got=%h exp=%h", {pc, fv, cnt}, {32'h0, 1'b1, 32'd0});
        end
        step();
        total++; if ({pc, fv, cnt} !== {32'h4, 1'b1, 32'd1}) begin
            bad++; $display("FAIL run_pc4 got=%h exp=%h", {pc, fv, cnt}, {32'h4, 1'b1, 32'd1});
        end
        step();
        total++; if ({pc, fv, cnt} !== {32'h8, 1'b1, 32'd2}) begin
            bad++; $display("FAIL run_pc8 got=%h exp=%h", {pc, fv, cnt}, {32'h8, 1'b1, 32'd2});
        end
        step();
        total++; if ({pc, plus4, fv, cnt} !== {32'hC, 32'h10, 1'b1, 32'd3}) begin
            bad++; $display("FAIL run_pcC got=%h exp=%h", {pc, plus4, fv, cnt}, {32'hC, 32'h10, 1'b1, 32'd3});
        end
    endtask

    task automatic test_priority();
        step();
        total++; if ({pc, cnt} !== {32'h10, 32'd4}) begin
            bad++; $display("FAIL prio_setup got=%h exp=%h", {pc, cnt}, {32'h10, 32'd4});
        end
        branch_taken = 1'b1; branch_target = 32'h40;
        jump_valid = 1'b1;   jump_target = 32'h80;
        step();
        total++; if ({pc, cnt} !== {32'h80, 32'd5}) begin
            bad++; $display("FAIL prio_jump_over_branch got=%h exp=%h", {pc, cnt}, {32'h80, 32'd5});
        end
        jump_valid = 1'b0;
        step();
        total++; if ({pc, cnt} !== {32'h40, 32'd6}) begin
            bad++; $display("FAIL prio_branch got=%h exp=%h", {pc, cnt}, {32'h40, 32'd6});
        end
        branch_taken = 1'b0;
        step();
        total++; if ({pc, cnt} !== {32'h44, 32'd7}) begin
            bad++; $display("FAIL prio_seq_after_branch got=%h exp=%h", {pc, cnt}, {32'h44, 32'd7});
        end
    endtask

    task automatic test_stall();
        jump_valid = 1'b1; jump_target = 32'h8;
        step();
        jump_valid = 1'b0;
        total++; if ({pc, cnt} !== {32'h8, 32'd8}) begin
            bad++; $display("FAIL stall_setup got=%h exp=%h", {pc, cnt}, {32'h8, 32'd8});
        end
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({pc, fv, cnt} !== {32'h8, 1'b1, 32'd8}) begin
                bad++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, {pc, fv, cnt}, {32'h8, 1'b1, 32'd8});
            end
        end
        stall = 1'b0; branch_taken = 1'b0;
        step();
        total++; if ({pc, cnt} !== {32'hC, 32'd9}) begin
            bad++; $display("FAIL stall_release got=%h exp=%h", {pc, cnt}, {32'hC, 32'd9});
        end
    endtask

    task automatic test_misaligned();
        jump_valid = 1'b1; jump_target = 32'h22;
        step();
        total++; if ({pc, plus4, fv, flt, cause, fpc, cnt} !== {32'hC, 32'h10, 1'b0, 1'b1, 2'b01, 32'h22, 32'd10}) begin
            bad++; $display("FAIL misaligned_fault got=%h exp=%h", {pc, plus4, fv, flt, cause, fpc, cnt}, {32'hC, 32'h10, 1'b0, 1'b1, 2'b01, 32'h22, 32'd10});
        end
        jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h1001;
        step();
        jump_valid = 1'b0; stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        branch_taken = 1'b0;
        total++; if ({pc, fv, flt, cause, fpc, cnt} !== {32'hC, 1'b0, 1'b1, 2'b01, 32'h22, 32'd10}) begin
            bad++; $display("FAIL fault_frozen got=%h exp=%h", {pc, fv, flt, cause, fpc, cnt}, {32'hC, 1'b0, 1'b1, 2'b01, 32'h22, 32'd10});
        end
    endtask

    task automatic test_reset_in_fault();
        rst = 1'b1; stall = 1'b1;
        step();
        total++; if ({pc, fv, flt, cause, fpc, cnt} !== {32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'd0}) begin
            bad++; $display("FAIL fault_reset got=%h exp=%h", {pc, fv, flt, cause, fpc, cnt}, {32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'd0});
        end
        rst = 1'b0; stall = 1'b0;
        step();
        total++; if ({pc, fv, flt, cnt} !== {32'h0, 1'b1, 1'b0, 32'd0}) begin
            bad++; $display("FAIL fault_reset_boot got=%h exp=%h", {pc, fv, flt, cnt}, {32'h0, 1'b1, 1'b0, 32'd0});
        end
        step();
        total++; if ({pc, fv, cnt} !== {32'h4, 1'b1, 32'd1}) begin
            bad++; $display("FAIL fault_reset_resume got=%h exp=%h", {pc, fv, cnt}, {32'h4, 1'b1, 32'd1});
        end
    endtask

    task automatic test_range_runoff();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        total++; if ({s_pc, s_fv, s_cnt} !== {32'h0, 1'b1, 32'd0}) begin
            bad++; $display("FAIL small_boot got=%h exp=%h", {s_pc, s_fv, s_cnt}, {32'h0, 1'b1, 32'd0});
        end
        step(); step(); step();
        total++; if ({s_pc, s_plus4, s_fv, s_flt, s_cnt} !== {32'hC, 32'h10, 1'b1, 1'b0, 32'd3}) begin
            bad++; $display("FAIL small_last_word got=%h exp=%h", {s_pc, s_plus4, s_fv, s_flt, s_cnt}, {32'hC, 32'h10, 1'b1, 1'b0, 32'd3});
        end
        step();
        total++; if ({s_pc, s_fv, s_flt, s_cause, s_fpc, s_cnt} !== {32'hC, 1'b0, 1'b1, 2'b10, 32'h10, 32'd4}) begin
            bad++; $display("FAIL runoff_fault got=%h exp=%h", {s_pc, s_fv, s_flt, s_cause, s_fpc, s_cnt}, {32'hC, 1'b0, 1'b1, 2'b10, 32'h10, 32'd4});
        end
        branch_taken = 1'b1; branch_target = 32'h4;
        step();
        branch_taken = 1'b0;
        total++; if ({s_pc, s_flt, s_cause, s_fpc, s_cnt} !== {32'hC, 1'b1, 2'b10, 32'h10, 32'd4}) begin
            bad++; $display("FAIL runoff_frozen got=%h exp=%h", {s_pc, s_flt, s_cause, s_fpc, s_cnt}, {32'hC, 1'b1, 2'b10, 32'h10, 32'd4});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        branch_taken = 1'b1; branch_target = 32'h13;
        step();
        branch_taken = 1'b0;
        total++; if ({s_pc, s_fv, s_flt, s_cause, s_fpc, s_cnt} !== {32'h0, 1'b0, 1'b1, 2'b11, 32'h13, 32'd1}) begin
            bad++; $display("FAIL both_causes got=%h exp=%h", {s_pc, s_fv, s_flt, s_cause, s_fpc, s_cnt}, {32'h0, 1'b0, 1'b1, 2'b11, 32'h13, 32'd1});
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump_valid = 1'b0;   jump_target = 32'h0;
        @(negedge clk);
        test_reset();
        test_priority();
        test_stall();
        test_misaligned();
        test_reset_in_fault();
        test_range_runoff();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
